// File: rtl/gaussian3x3_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : gaussian3x3_stream_if
// Description : Pixel-in / pixel-out valid-ready bundle for the 3x3 blur stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface gaussian3x3_stream_if #(
    parameter int PIXEL_BIT_WIDTH = 16
);
    logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
    logic                       in_valid;
    logic                       in_ready;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    modport slave (
        input  pixel_in, in_valid, out_ready,
        output in_ready, pixel_out, out_valid, out_last
    );

    modport master (
        output pixel_in, in_valid, out_ready,
        input  in_ready, pixel_out, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/gaussian3x3_stream.sv
`default_nettype none
// ============================================================================
// Module      : gaussian3x3_stream
// Description : Streaming 3x3 Gaussian blur, valid-region output, 1-cycle
//               latency. Define GAUSS3X3_ROUND_EN for round-half-up results.
// Revision    : 1.0 - initial release
// ============================================================================
module gaussian3x3_stream #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int ROWS            = 48,
    parameter int COLS            = 48
) (
    input wire                 clk,
    input wire                 reset,
    gaussian3x3_stream_if.slave io_stream
);
    localparam int c_PW = PIXEL_BIT_WIDTH;
    localparam int c_SW = PIXEL_BIT_WIDTH + 4;
    localparam int c_RW = $clog2(ROWS);
    localparam int c_CW = $clog2(COLS);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(ROWS - 1);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(COLS - 1);
    localparam logic [c_RW-1:0] c_ROW_TWO  = c_RW'(2);
    localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);

    logic [c_RW-1:0]        r_row;
    logic [c_CW-1:0]        r_col;
    logic [c_PW-1:0]        r_lb0 [COLS];
    logic [c_PW-1:0]        r_lb1 [COLS];
    logic [c_PW-1:0]        r_win [3][3];
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [c_PW-1:0]        r_pixel_out;

    logic [c_PW-1:0]        w_col [3];
    logic [c_PW-1:0]        w_win [3][3];
    logic signed [c_SW-1:0] w_sum;
    logic signed [c_SW-1:0] w_biased;
    logic                   w_accept;
    logic                   w_produce;
    logic                   w_col_end;
    logic                   w_frame_end;

    assign io_stream.in_ready  = reset & (~r_out_valid | io_stream.out_ready);
    assign io_stream.out_valid = r_out_valid;
    assign io_stream.out_last  = r_out_last;
    assign io_stream.pixel_out = r_pixel_out;

    assign w_accept    = io_stream.in_valid & io_stream.in_ready;
    assign w_col_end   = (r_col == c_COL_LAST);
    assign w_frame_end = w_col_end & (r_row == c_ROW_LAST);
    assign w_produce   = w_accept & (r_row >= c_ROW_TWO) & (r_col >= c_COL_TWO);

    // Window as it will look after this accept: rows top-to-bottom oldest
    // first, column 2 is the incoming column.
    always_comb begin
        w_col[0] = r_lb1[r_col];
        w_col[1] = r_lb0[r_col];
        w_col[2] = io_stream.pixel_in;
        for (int i = 0; i < 3; i++) begin
            w_win[i][0] = r_win[i][1];
            w_win[i][1] = r_win[i][2];
            w_win[i][2] = w_col[i];
        end
    end

    // Kernel weights are 1/2/4, so each tap is a shift by (row==1)+(col==1).
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_sum = w_sum + ($signed({{4{w_win[i][j][c_PW-1]}}, w_win[i][j]})
                                 <<< ((i == 1 ? 1 : 0) + (j == 1 ? 1 : 0)));
            end
        end
    end

`ifdef GAUSS3X3_ROUND_EN
    assign w_biased = w_sum + c_SW'(8);
`else
    assign w_biased = w_sum;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row       <= '0;
            r_col       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pixel_out <= '0;
        end else begin
            if (w_accept) begin
                if (w_frame_end) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (w_col_end) begin
                    r_row <= r_row + 1'b1;
                    r_col <= '0;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            // An accept implies the register is empty or draining this edge.
            if (w_produce) begin
                r_out_valid <= 1'b1;
                r_pixel_out <= c_PW'(w_biased >>> 4);
                r_out_last  <= w_frame_end;
            end else if (io_stream.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Pixel storage needs no reset; stale contents never reach the output.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= io_stream.pixel_in;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= w_win[i][j];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gaussian3x3_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_gaussian3x3_stream
// Description : Randomized scoreboard bench for gaussian3x3_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gaussian3x3_stream;
    localparam int PW   = 16;
    localparam int ROWS = 48;
    localparam int COLS = 48;
    localparam int OC   = COLS - 2;
    localparam int NOUT = (ROWS - 2) * (COLS - 2);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    gaussian3x3_stream_if #(.PIXEL_BIT_WIDTH(PW)) bus ();

    gaussian3x3_stream #(
        .PIXEL_BIT_WIDTH(PW),
        .ROWS           (ROWS),
        .COLS           (COLS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .io_stream(bus.slave)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [PW-1:0] stim [$];
    logic [PW:0]   expq [$];
    int            fr [ROWS][COLS];
    logic [PW-1:0] cap [NOUT];
    int            tot_out = 0;
    int            tot_last = 0;
    int            out_idx = 0;
    int            acc_cnt = 0;
    bit            first_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int idx(input int r, input int c);
        return (r - 1) * OC + (c - 1);
    endfunction

    // kind: 0 constant amp, 1 ramp r*COLS+c, 2 impulse amp at (10,10), 3 random
    task automatic build_frame(input int kind, input int amp);
        logic signed [PW-1:0] t;
        int s, q, w;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                case (kind)
                    0:       fr[r][c] = amp;
                    1:       fr[r][c] = r * COLS + c;
                    2:       fr[r][c] = (r == 10 && c == 10) ? amp : 0;
                    default: begin t = PW'($urandom); fr[r][c] = int'(t); end
                endcase
                stim.push_back(PW'(fr[r][c]));
            end
        end
        for (int r = 1; r < ROWS - 1; r++) begin
            for (int c = 1; c < COLS - 1; c++) begin
                s = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        w = (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
                        s += w * fr[r + dr][c + dc];
                    end
                end
`ifdef GAUSS3X3_ROUND_EN
                q = (s + 8) >>> 4;
`else
                q = s >>> 4;
`endif
                expq.push_back({1'((r == ROWS - 2) && (c == COLS - 2)), PW'(q)});
            end
        end
    endtask

    task automatic checker_loop();
        logic [PW:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                out_idx    = 0;
                acc_cnt    = 0;
                first_seen = 1'b0;
            end else begin
                if (bus.out_valid && !first_seen) begin
                    first_seen = 1'b1;
                    check("first_out_latency", acc_cnt, 2 * COLS + 3);
                end
                if (bus.in_valid && bus.in_ready) acc_cnt++;
                if (bus.out_valid && bus.out_ready) begin
                    if (expq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: got %0h, required none", bus.pixel_out);
                    end else begin
                        e = expq.pop_front();
                        check("pixel_out", 32'(bus.pixel_out), 32'(e[PW-1:0]));
                        check("out_last", 32'(bus.out_last), 32'(e[PW]));
                    end
                    if (out_idx < NOUT) cap[out_idx] = bus.pixel_out;
                    tot_out++;
                    if (bus.out_last) begin
                        tot_last++;
                        out_idx = 0;
                    end else begin
                        out_idx++;
                    end
                end
            end
        end
    endtask

    task automatic stall50();
        logic [PW-1:0] p;
        logic          l;
        p = bus.pixel_out;
        l = bus.out_last;
        bus.out_ready = 1'b0;
        bus.in_valid  = (stim.size() > 0);
        repeat (50) begin
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_pixel_out", 32'(bus.pixel_out), 32'(p));
            check("stall_out_last", 32'(bus.out_last), 32'(l));
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input int vpct, input int rpct, input bit do_stall, input int rst_at);
        int cyc = 0;
        int nacc = 0;
        bit fire;
        bit stalled = 1'b0;
        while ((stim.size() > 0 || expq.size() > 0) && cyc < 40000) begin
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (fire) begin
                void'(stim.pop_front());
                nacc++;
            end
            if (rst_at >= 0 && nacc == rst_at) begin
                #2 reset = 1'b0;
                #1;
                check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
                check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
                check("midrst_pixel_out", 32'(bus.pixel_out), 32'd0);
                stim.delete();
                expq.delete();
                bus.in_valid = 1'b0;
                repeat (3) @(posedge clk);
                #3 reset = 1'b1;
                return;
            end
            bus.in_valid  = (stim.size() > 0) && ($urandom_range(99) < vpct);
            bus.pixel_in  = (stim.size() > 0) ? stim[0] : '0;
            bus.out_ready = ($urandom_range(99) < rpct);
            if (do_stall && !stalled && bus.out_valid) begin
                stalled = 1'b1;
                stall50();
            end
        end
        if (cyc >= 40000) begin
            n_vec++;
            n_err++;
            $display("FAIL drive_timeout: got %0d pending outputs, required 0", expq.size());
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int base, lbase;
        bus.in_valid  = 1'b0;
        bus.pixel_in  = '0;
        bus.out_ready = 1'b1;
        fork
            checker_loop();
        join_none

        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_pixel_out", 32'(bus.pixel_out), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        base = tot_out; lbase = tot_last;
        build_frame(0, 100);
        drive(100, 100, 1'b0, -1);
        check("const_count", tot_out - base, NOUT);
        check("const_lasts", tot_last - lbase, 1);
        check("const_first", 32'(cap[0]), 32'd100);
        check("const_last_val", 32'(cap[NOUT-1]), 32'd100);

        build_frame(1, 0);
        drive(100, 100, 1'b0, -1);
        check("ramp_first", 32'(cap[0]), 32'd49);
        check("ramp_mid", 32'(cap[1000]), 32'd1091);
        check("ramp_last", 32'(cap[NOUT-1]), 32'd2254);

        build_frame(2, 160);
        drive(100, 100, 1'b0, -1);
        check("imp_centre", 32'(cap[idx(10, 10)]), 32'd40);
        check("imp_up", 32'(cap[idx(9, 10)]), 32'd20);
        check("imp_right", 32'(cap[idx(10, 11)]), 32'd20);
        check("imp_corner_ul", 32'(cap[idx(9, 9)]), 32'd10);
        check("imp_corner_dr", 32'(cap[idx(11, 11)]), 32'd10);
        check("imp_far", 32'(cap[idx(5, 5)]), 32'd0);

        build_frame(2, 2);
        drive(100, 100, 1'b0, -1);
`ifdef GAUSS3X3_ROUND_EN
        check("round_pos_centre", 32'(cap[idx(10, 10)]), 32'd1);
`else
        check("round_pos_centre", 32'(cap[idx(10, 10)]), 32'd0);
`endif

        build_frame(2, -1);
        drive(100, 100, 1'b0, -1);
`ifdef GAUSS3X3_ROUND_EN
        check("round_neg_corner", 32'(cap[idx(9, 9)]), 32'h0000);
`else
        check("round_neg_corner", 32'(cap[idx(9, 9)]), 32'hFFFF);
`endif

        base = tot_out;
        build_frame(1, 0);
        drive(100, 100, 1'b1, -1);
        check("stall_count", tot_out - base, NOUT);

        base = tot_out; lbase = tot_last;
        build_frame(0, 100);
        build_frame(1, 0);
        build_frame(3, 0);
        drive(70, 60, 1'b0, -1);
        check("random_count", tot_out - base, 3 * NOUT);
        check("random_lasts", tot_last - lbase, 3);

        build_frame(1, 0);
        drive(100, 100, 1'b0, 1000);
        @(posedge clk);
        #1;
        base = tot_out;
        build_frame(1, 0);
        drive(80, 80, 1'b0, -1);
        check("post_rst_count", tot_out - base, NOUT);
        check("post_rst_last_val", 32'(cap[NOUT-1]), 32'd2254);

        base = tot_out; lbase = tot_last;
        build_frame(1, 0);
        build_frame(1, 0);
        drive(75, 70, 1'b0, -1);
        check("b2b_count", tot_out - base, 2 * NOUT);
        check("b2b_lasts", tot_last - lbase, 2);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/gaussian3x3_stream.md
Name: gaussian3x3_stream

Overview:
Streaming 3x3 Gaussian blur stage directly downstream of crop_plus_fifo in the crop-plus-gaussian pipeline. Consumes the cropped OUT_ROWS x OUT_COLS frame in raster order over valid/ready and emits the valid-region convolution, a (ROWS-2) x (COLS-2) frame, over valid/ready. Uses two line buffers, a 3x3 window register and one registered output stage.

Parameters:
PIXEL_BIT_WIDTH, 16, pixel width; signed two's complement, integer-only fixed point.
ROWS, 48, input frame rows; must be >= 3.
COLS, 48, input frame columns; must be >= 3.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
pixel_in  input  PIXEL_BIT_WIDTH  input pixel, raster order.
in_valid  input  1  pixel_in is valid.
in_ready  output  1  block accepts pixel_in this cycle.
pixel_out  output  PIXEL_BIT_WIDTH  filtered pixel, raster order.
out_valid  output  1  pixel_out is valid.
out_ready  input  1  downstream accepts pixel_out.
out_last  output  1  qualifies pixel_out as the final pixel of the output frame.

Behaviour:
- Reset (reset=0, asynchronous): row/col counters=0, out_valid=0, pixel_out=0, out_last=0, in_ready=0 while reset is held. Line buffer contents are don't-care.
- in_ready = reset & (~out_valid | out_ready). A transfer occurs when in_valid & in_ready.
- Input accept at (r,c): shift the window one column. The new column is {linebuf1[c], linebuf0[c], pixel_in}, oldest row on top. Then linebuf1[c] <= linebuf0[c] and linebuf0[c] <= pixel_in.
- col increments on each accept. At COLS-1 it wraps to 0 and row increments. At (ROWS-1, COLS-1), row and col both wrap to 0 and the next frame starts with no idle cycle.
- Output generation: an accept with r>=2 and c>=2 produces the result for the window of rows r-2..r and cols c-2..c, centred at (r-1, c-1).
- Output register: on that accept, pixel_out and out_valid=1 are loaded on the same edge, giving 1-cycle latency from accept to out_valid.
- out_last is loaded as 1 only when (r,c) = (ROWS-1, COLS-1); otherwise it is loaded as 0.
- An accept with r<2 or c<2 is consumed silently. If the output register is empty or draining, out_valid becomes 0 on that edge.
- Output transfer: out_valid & out_ready. If no new result loads on the same edge, out_valid clears.
- Simultaneous output drain and new result: the new result loads and out_valid stays 1.
- Backpressure: while out_valid=1 and out_ready=0, pixel_out and out_last stay stable and in_ready=0.
- Arithmetic: kernel [1 2 1; 2 4 2; 1 2 1].
  - Sum is computed sign-extended to PIXEL_BIT_WIDTH+4 bits, with no overflow possible.
  - Result = sum >>> 4 (arithmetic shift, floor), truncated to PIXEL_BIT_WIDTH.
  - No saturation is needed, since the result is a weighted average of representable values.
- Throughput: 1 pixel/cycle when in_valid=1 and out_ready=1 continuously.
- Output count per frame: (ROWS-2)*(COLS-2), i.e. 2116 for 48x48.
- Reset mid-frame: counters restart at (0,0). Any pending output is discarded (out_valid=0). The next accepted pixel is treated as frame pixel (0,0).

Optional Feature:
GAUSS3X3_ROUND_EN
- Defined: result = (sum + 8) >>> 4, round half toward +infinity.
- Undefined: result = sum >>> 4, floor.
- Both modes have identical latency, handshake and ports.

Test Plan:
- Constant frame 100, 48x48, in_valid=out_ready=1 -> exactly 2116 outputs, all 100. out_last=1 only on output 2116. out_valid first rises 1 cycle after accepting input (2,2).
- Ramp frame, value = r*48+c (index data) -> output k (k=0..2115, r'=k/46, c'=k%46) equals (r'+1)*48+(c'+1). The linear ramp is preserved exactly in both rounding modes.
- Impulse 160 at (10,10), rest 0 -> output centred at (10,10)=40, centres (9,10) and (10,11)=20, centres (9,9) and (11,11)=10, all others 0.
- Rounding: impulse 2 at (10,10) -> centre output 0 (floor) or 1 (ROUND_EN). Impulse -1 at (10,10) -> corner-neighbour output -1 (floor) or 0 (ROUND_EN).
- Backpressure: hold out_ready=0 for 50 cycles with in_valid=1 after the first result -> out_valid=1, pixel_out and out_last stable, in_ready=0. On release the stream resumes, and the output sequence matches the no-stall run exactly. Also run with random in_valid/out_ready and compare against the constant-frame and ramp references.
- Reset mid-frame: drive reset=0 asynchronously at input pixel 1000 -> out_valid=0 and in_ready=0 immediately. After release, a full ramp frame yields exactly 2116 correct outputs. Two back-to-back frames yield 4232 outputs with two out_last pulses.
